// File: rtl/fifo_sync_param_if.sv
// Handshake, data and status bundle between a producer/consumer (master) and the FIFO (slave).
interface fifo_sync_param_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             wr_ack;
  logic             overflow;
  logic             underflow;
  logic             full;
  logic             empty;
  logic             almostfull;
  logic             almostempty;
  logic [CW-1:0]    count;

  modport master (
    output wr_en, rd_en, data_in,
    input  data_out, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  wr_en, rd_en, data_in,
    output data_out, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable thresholds, occupancy count
// and an optional first-word-fall-through read path.
module fifo_sync_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_TH      = FIFO_DEPTH - 1,
  parameter int AE_TH      = 1,
  parameter int FWFT       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_sync_param_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_TH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  wr_reject;
  logic                  rd_reject;

  // Status flags are decoded straight from the registered count.
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
  assign wr_accept = bus.wr_en && (!full || bus.rd_en);
  assign wr_reject = bus.wr_en && full && !bus.rd_en;
  assign rd_accept = bus.rd_en && !empty;
  assign rd_reject = bus.rd_en && empty;

  // Storage is deliberately left out of reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= bus.data_in;
  end

  // Pointers, occupancy and the single-cycle event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.wr_ack    <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
      if (rd_accept) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_accept, rd_accept})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      bus.wr_ack    <= wr_accept;
      bus.overflow  <= wr_reject;
      bus.underflow <= rd_reject;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented combinationally; zero whenever nothing is stored.
      always_comb begin
        bus.data_out = '0;
        if (!empty) bus.data_out = mem[rd_ptr];
      end
    end else begin : g_reg
      logic [FIFO_WIDTH-1:0] data_q;

      // Registered read: capture the head on an accepted read, hold otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         data_q <= '0;
        else if (rd_accept) data_q <= mem[rd_ptr];
      end

      assign bus.data_out = data_q;
    end
  endgenerate

  assign bus.count       = count;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count >= AF_C) && (count < DEPTH_C);
  assign bus.almostempty = (count <= AE_C) && (count != '0);
endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a default registered-read FIFO and a 32x16 FWFT FIFO,
// each compared against a queue-based reference model.
module tb_fifo_sync_param;
  localparam int A_W = 16, A_D = 8,  A_AF = 7,  A_AE = 1;
  localparam int B_W = 32, B_D = 16, B_AF = 15, B_AE = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(A_W), .DEPTH(A_D)) a ();
  fifo_sync_param_if #(.WIDTH(B_W), .DEPTH(B_D)) b ();

  fifo_sync_param #(.FIFO_WIDTH(A_W), .FIFO_DEPTH(A_D)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a)
  );
  fifo_sync_param #(.FIFO_WIDTH(B_W), .FIFO_DEPTH(B_D), .FWFT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [A_W-1:0] qa [$];
  logic [B_W-1:0] qb [$];
  logic [A_W-1:0] da = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step_a(input logic wr, input logic rd, input logic [A_W-1:0] din);
    int n;
    logic rd_ok, wr_ok;
    @(negedge clk);
    a.wr_en = wr; a.rd_en = rd; a.data_in = din;
    n = qa.size();
    rd_ok = rd && (n != 0);
    wr_ok = wr && ((n != A_D) || rd);
    @(posedge clk);
    if (rd_ok) da = qa.pop_front();
    if (wr_ok) qa.push_back(din);
    n = qa.size();
    #1;
    chk("a_wr_ack",    32'(a.wr_ack),      32'(wr_ok));
    chk("a_overflow",  32'(a.overflow),    32'(wr && !wr_ok));
    chk("a_underflow", 32'(a.underflow),   32'(rd && !rd_ok));
    chk("a_count",     32'(a.count),       32'(n));
    chk("a_full",      32'(a.full),        32'(n == A_D));
    chk("a_empty",     32'(a.empty),       32'(n == 0));
    chk("a_afull",     32'(a.almostfull),  32'((n >= A_AF) && (n < A_D)));
    chk("a_aempty",    32'(a.almostempty), 32'((n <= A_AE) && (n > 0)));
    chk("a_data_out",  32'(a.data_out),    32'(da));
  endtask

  task automatic step_b(input logic wr, input logic rd, input logic [B_W-1:0] din);
    int n;
    logic rd_ok, wr_ok;
    @(negedge clk);
    b.wr_en = wr; b.rd_en = rd; b.data_in = din;
    n = qb.size();
    rd_ok = rd && (n != 0);
    wr_ok = wr && ((n != B_D) || rd);
    @(posedge clk);
    if (rd_ok) void'(qb.pop_front());
    if (wr_ok) qb.push_back(din);
    n = qb.size();
    #1;
    chk("b_wr_ack",    32'(b.wr_ack),      32'(wr_ok));
    chk("b_overflow",  32'(b.overflow),    32'(wr && !wr_ok));
    chk("b_underflow", 32'(b.underflow),   32'(rd && !rd_ok));
    chk("b_count",     32'(b.count),       32'(n));
    chk("b_full",      32'(b.full),        32'(n == B_D));
    chk("b_empty",     32'(b.empty),       32'(n == 0));
    chk("b_afull",     32'(b.almostfull),  32'((n >= B_AF) && (n < B_D)));
    chk("b_aempty",    32'(b.almostempty), 32'((n <= B_AE) && (n > 0)));
    chk("b_data_out",  b.data_out,         (n != 0) ? qb[0] : 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a.wr_en = 1'b0; a.rd_en = 1'b0; a.data_in = '0;
    b.wr_en = 1'b0; b.rd_en = 1'b0; b.data_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_empty",   32'(a.empty),       32'd1);
    chk("rst_a_full",    32'(a.full),        32'd0);
    chk("rst_a_count",   32'(a.count),       32'd0);
    chk("rst_a_afull",   32'(a.almostfull),  32'd0);
    chk("rst_a_aempty",  32'(a.almostempty), 32'd0);
    chk("rst_a_dout",    32'(a.data_out),    32'd0);
    chk("rst_b_empty",   32'(b.empty),       32'd1);
    chk("rst_b_dout",    b.data_out,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full, then overflow.
    for (int i = 1; i <= 8; i++) step_a(1'b1, 1'b0, 16'(i));
    chk("t1_full", 32'(a.full), 32'd1);
    step_a(1'b1, 1'b0, 16'hDEAD);
    chk("t1_overflow", 32'(a.overflow), 32'd1);

    // Drain, then underflow with data_out held.
    for (int i = 1; i <= 8; i++) step_a(1'b0, 1'b1, 16'h0);
    step_a(1'b0, 1'b1, 16'h0);
    chk("t2_underflow", 32'(a.underflow), 32'd1);
    chk("t2_hold",      32'(a.data_out),  32'h0008);

    // Simultaneous read/write while full.
    for (int i = 1; i <= 8; i++) step_a(1'b1, 1'b0, 16'(i));
    for (int i = 0; i < 3; i++) step_a(1'b1, 1'b1, 16'(16'hA0 + i));
    chk("t3_count", 32'(a.count), 32'd8);
    for (int i = 0; i < 5; i++) step_a(1'b0, 1'b1, 16'h0);
    chk("t3_last_old", 32'(a.data_out), 32'h0008);
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 16'h0);
    chk("t3_last_new", 32'(a.data_out), 32'h00A2);

    // Simultaneous read/write while empty.
    step_a(1'b1, 1'b1, 16'h5555);
    chk("t4_underflow", 32'(a.underflow), 32'd1);
    chk("t4_wr_ack",    32'(a.wr_ack),    32'd1);
    step_a(1'b0, 1'b1, 16'h0);
    chk("t4_data", 32'(a.data_out), 32'h5555);

    // FWFT visibility without rd_en.
    step_b(1'b1, 1'b0, 32'hCAFEF00D);
    chk("t5_fwft_head", b.data_out, 32'hCAFEF00D);
    step_b(1'b0, 1'b1, 32'h0);
    chk("t5_fwft_zero",  b.data_out,     32'h0);
    chk("t5_fwft_empty", 32'(b.empty),   32'd1);

    // Randomised traffic, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 400; i++) begin
      int pw;
      pw = ((i / 50) % 2 == 0) ? 75 : 30;
      step_a($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), 16'($urandom));
    end
    step_a(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 300; i++) begin
      int pw;
      pw = ((i / 60) % 2 == 0) ? 80 : 25;
      step_b($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), $urandom);
    end
    step_b(1'b0, 1'b0, 32'h0);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) step_a(1'b1, 1'b0, 16'(16'h100 + i));
    @(negedge clk);
    a.wr_en = 1'b0; a.rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    qa.delete(); qb.delete(); da = '0;
    chk("t6_dout",   32'(a.data_out),    32'd0);
    chk("t6_count",  32'(a.count),       32'd0);
    chk("t6_empty",  32'(a.empty),       32'd1);
    chk("t6_full",   32'(a.full),        32'd0);
    chk("t6_wr_ack", 32'(a.wr_ack),      32'd0);
    chk("t6_ovf",    32'(a.overflow),    32'd0);
    chk("t6_unf",    32'(a.underflow),   32'd0);
    chk("t6_afull",  32'(a.almostfull),  32'd0);
    chk("t6_aempty", 32'(a.almostempty), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step_a(1'b1, 1'b0, 16'h0042);
    step_a(1'b0, 1'b1, 16'h0);
    chk("t6_data",  32'(a.data_out), 32'h0042);
    chk("t6_count_after", 32'(a.count), 32'd0);
    step_a(1'b0, 1'b0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO. Next generation of the team's 8-deep, 16-bit FIFO.
- Adds:
  - configurable width and depth,
  - programmable almost-full and almost-empty thresholds,
  - an occupancy count output,
  - a first-word-fall-through (FWFT) read mode.
- Sits between a single-clock producer and consumer.
- Keeps the existing handshake and status-flag contract, so current benches and coverage port with only parameter changes.

Parameters:
- FIFO_WIDTH, 16, data width in bits (1..256).
- FIFO_DEPTH, 8, number of entries; power of two, 2..1024.
- AF_TH, FIFO_DEPTH-1, almostfull asserts when count >= AF_TH and count < FIFO_DEPTH.
- AE_TH, 1, almostempty asserts when count <= AE_TH and count > 0.
- FWFT, 0, 0 = registered read (1-cycle latency), 1 = head entry visible on data_out without rd_en.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- rd_en  in  1  read request
- data_in  in  FIFO_WIDTH  write data
- data_out  out  FIFO_WIDTH  read data
- wr_ack  out  1  registered; 1 for one cycle after an accepted write
- overflow  out  1  registered; 1 for one cycle after a rejected write
- underflow  out  1  registered; 1 for one cycle after a rejected read
- full  out  1  combinational, count == FIFO_DEPTH
- empty  out  1  combinational, count == 0
- almostfull  out  1  combinational, per AF_TH
- almostempty  out  1  combinational, per AE_TH
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_n low, async):
  - wr_ptr, rd_ptr, count, data_out, wr_ack, overflow, underflow all go to 0.
  - Result: empty=1, full=0, almostempty=0, almostfull=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data. The first read after release sees only data written after release.
- Accepted write:
  - Condition: wr_en && (!full || rd_en).
  - Action: mem[wr_ptr] <= data_in, wr_ptr increments, wr_ack=1 next cycle.
- Rejected write:
  - Condition: wr_en && full && !rd_en.
  - Action: no state change, overflow=1 next cycle, wr_ack=0.
- Accepted read:
  - Condition: rd_en && !empty.
  - Action: rd_ptr increments.
- Rejected read:
  - Condition: rd_en && empty.
  - Action: underflow=1 next cycle. This holds even if a simultaneous write is accepted.
- Simultaneous rd_en && wr_en:
  - full: read and write both succeed, count unchanged, full stays 1, overflow=0.
  - empty: write only, count becomes 1, underflow=1.
  - otherwise: both succeed, count unchanged.
- count update:
  - +1 on write-only, -1 on read-only, unchanged on both or neither.
  - Never exceeds FIFO_DEPTH and never wraps below 0.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap from FIFO_DEPTH-1 to 0.
- FWFT=0:
  - On an accepted read, data_out <= mem[rd_ptr] at that clock edge.
  - Otherwise data_out holds its value.
- FWFT=1:
  - data_out = mem[rd_ptr] when !empty, 0 when empty. No registered read stage.
  - The first write into an empty FIFO appears on data_out the cycle after the write edge.
- Flags derive from count after the edge. All flags are glitch-free relative to clk.
- wr_ack, overflow and underflow are single-cycle pulses. They are 0 in any cycle following an edge with no corresponding event.

Test Plan:
1. Reset, then 8 writes 0x0001..0x0008 (defaults) -> wr_ack=1 each cycle. count goes 1..8. almostfull=1 at count=7, full=1 at count=8. A 9th write with data 0xDEAD gives overflow=1 and count stays 8.
2. From full, 8 reads (FWFT=0) -> data_out = 0x0001..0x0008, each valid the cycle after rd_en. almostempty=1 at count=1, empty=1 at count=0. A 9th read gives underflow=1 and data_out holds 0x0008.
3. Full FIFO with rd_en=wr_en=1 for 3 cycles, data 0xA0..0xA2 -> count stays 8, no overflow. The following reads return 0x0004..0x0008, then 0xA0..0xA2.
4. Empty FIFO with rd_en=wr_en=1, data 0x5555 -> underflow=1, wr_ack=1, count=1. The next read returns 0x5555.
5. FWFT=1, FIFO_WIDTH=32, FIFO_DEPTH=16: write 0xCAFEF00D -> data_out=0xCAFEF00D one cycle later with no rd_en. After one read, data_out=0 and empty=1.
6. Write 5 entries, drop rst_n asynchronously between clock edges -> all outputs are 0 and empty=1 immediately. After release, write 0x0042 and read it: data_out=0x0042 and count=0.
